// File: rtl/i2c_sram_pkg.sv
// Shared definitions for the burst I2C SRAM: FSM encoding, bus response levels,
// default geometry.
package i2c_sram_pkg;

    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_DATA_BYTES = 2;

    // Level of the ninth (response) bit on the bus
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StDevAddr  = 4'd1,
        StDevAck   = 4'd2,
        StMemAddr  = 4'd3,
        StMemAck   = 4'd4,
        StWrByte   = 4'd5,
        StWrAck    = 4'd6,
        StRdByte   = 4'd7,
        StRdAck    = 4'd8,
        StWaitStop = 4'd9
    } state_e;

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous RAM, DEPTH x DATA_W, write enable and registered read.
// Contents are deliberately not reset.
module sram_sp
    import i2c_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = 8 * DEF_DATA_BYTES,
    parameter int unsigned DEPTH  = 2 ** DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port plus one-cycle registered read of the same address
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/i2c_sram_burst.sv
// Oversampled I2C slave in front of a word-wide SRAM. Supports burst write/read with
// pointer auto-increment and wrap, current-address reads and repeated start.
module i2c_sram_burst
    import i2c_sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_BYTES = DEF_DATA_BYTES,
    parameter int unsigned DEPTH      = 2 ** ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scl,
    inout  wire                     sda,
    input  logic [6:0]              my_addr,
    output logic [8*DATA_BYTES-1:0] curr_data,
    output logic [6:0]              rcvd_device_address,
    output logic                    rcvd_mode,
    output logic [3:0]              state,
    output logic                    busy
);

    localparam int unsigned       W         = 8 * DATA_BYTES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(DATA_BYTES - 1);

    state_e            r_state, w_state_d;
    logic [1:0]        r_scl_sync, r_sda_sync;
    logic              r_scl_prev, r_sda_prev;
    logic [7:0]        r_shift, w_shift_d;
    logic [3:0]        r_bit_cnt, w_bit_cnt_d;
    logic [1:0]        r_byte_idx, w_byte_idx_d;
    logic [ADDR_W-1:0] r_ptr, w_ptr_d;
    logic [W-1:0]      r_wr_buf, w_wr_buf_d;
    logic [W-1:0]      r_rd_word, w_rd_word_d;
    logic [W-1:0]      r_curr_data, w_curr_data_d;
    logic              r_load, w_load_d;
    logic              r_prime, w_prime_d;
    logic              r_mack, w_mack_d;
    logic              r_sda_oe, w_sda_oe_d;
    logic [6:0]        r_rcvd_addr, w_rcvd_addr_d;
    logic              r_rcvd_mode, w_rcvd_mode_d;

    logic              w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]        w_byte_in, w_rd_byte;
    logic [1:0]        w_slot;
    logic [4:0]        w_sh;
    logic [W-1:0]      w_wr_word, w_rdata;
    logic              w_rd_bit;
    logic [ADDR_W-1:0] w_addr_field, w_ptr_load, w_ptr_inc, w_mem_raddr, w_mem_addr;
    logic              w_mem_we, w_mem_re;

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // Bus conditions need scl stable high across the sda transition
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // Byte lane of the current byte within a word; lane LAST_BYTE is sent first
    assign w_byte_in  = {r_shift[6:0], w_sda};
    assign w_slot     = LAST_BYTE - r_byte_idx;
    assign w_sh       = {w_slot, 3'b000};
    assign w_wr_word  = (r_wr_buf & ~(W'(8'hFF) << w_sh)) | (W'(w_byte_in) << w_sh);
    assign w_rd_byte  = 8'(r_rd_word >> w_sh);
    assign w_rd_bit   = w_rd_byte[3'd7 - r_bit_cnt[2:0]];

    assign w_addr_field = r_shift[ADDR_W-1:0];
    assign w_ptr_inc    = (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
    assign w_mem_addr   = w_mem_re ? w_mem_raddr : r_ptr;

    if (DEPTH < 2 ** ADDR_W) begin : g_wrap
        assign w_ptr_load = (32'(w_addr_field) < DEPTH) ? w_addr_field : '0;
    end else begin : g_full
        assign w_ptr_load = w_addr_field;
    end

    sram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_wr_word),
        .o_rdata (w_rdata)
    );

    // Next-state and datapath decode; START/STOP override any same-cycle scl edge
    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_bit_cnt_d   = r_bit_cnt;
        w_byte_idx_d  = r_byte_idx;
        w_ptr_d       = r_ptr;
        w_wr_buf_d    = r_wr_buf;
        w_rd_word_d   = r_rd_word;
        w_curr_data_d = r_curr_data;
        w_load_d      = r_load;
        w_prime_d     = r_prime;
        w_mack_d      = r_mack;
        w_sda_oe_d    = r_sda_oe;
        w_rcvd_addr_d = r_rcvd_addr;
        w_rcvd_mode_d = r_rcvd_mode;
        w_mem_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_raddr   = r_ptr;

        if (w_start || w_stop) begin
            w_state_d    = w_start ? StDevAddr : StIdle;
            w_bit_cnt_d  = '0;
            w_byte_idx_d = '0;
            w_sda_oe_d   = 1'b0;
            w_load_d     = 1'b0;
            w_prime_d    = 1'b0;
        end else begin
            unique case (r_state)
                StDevAddr: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte_in;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_rcvd_addr_d = r_shift[6:0];
                            w_rcvd_mode_d = w_sda;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt_d = '0;
                        if (r_rcvd_addr == my_addr) begin
                            w_sda_oe_d = 1'b1;
                            w_state_d  = StDevAck;
                        end else begin
                            w_state_d  = StWaitStop;
                        end
                    end
                end
                StDevAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d = 1'b0;
                        if (r_rcvd_mode) begin
                            // Current-address read: fetch the word at the pointer now
                            w_mem_re     = 1'b1;
                            w_load_d     = 1'b1;
                            w_byte_idx_d = '0;
                            w_state_d    = StRdByte;
                        end else begin
                            w_state_d    = StMemAddr;
                        end
                    end
                end
                StMemAddr: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte_in;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_ptr_d     = w_ptr_load;
                        w_bit_cnt_d = '0;
                        w_sda_oe_d  = 1'b1;
                        w_state_d   = StMemAck;
                    end
                end
                StMemAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d   = 1'b0;
                        w_byte_idx_d = '0;
                        w_state_d    = StWrByte;
                    end
                end
                StWrByte: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_byte_in;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_wr_buf_d = w_wr_word;
                            if (r_byte_idx == LAST_BYTE) begin
                                w_mem_we      = 1'b1;
                                w_curr_data_d = w_wr_word;
                                w_ptr_d       = w_ptr_inc;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt_d = '0;
                        w_sda_oe_d  = 1'b1;
                        w_state_d   = StWrAck;
                    end
                end
                StWrAck: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d   = 1'b0;
                        w_byte_idx_d = (r_byte_idx == LAST_BYTE) ? 2'd0 : r_byte_idx + 1'b1;
                        w_state_d    = StWrByte;
                    end
                end
                StRdByte: begin
                    if (r_load) begin
                        // Fetched word is valid: drive its first bit straight from RAM
                        w_load_d      = 1'b0;
                        w_rd_word_d   = w_rdata;
                        w_curr_data_d = w_rdata;
                        w_sda_oe_d    = ~w_rdata[W-1];
                    end else if (r_prime) begin
                        w_prime_d  = 1'b0;
                        w_sda_oe_d = ~w_rd_bit;
                    end else if (w_scl_rise) begin
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_bit_cnt_d = '0;
                            w_sda_oe_d  = 1'b0;
                            w_state_d   = StRdAck;
                        end else begin
                            w_sda_oe_d  = ~w_rd_bit;
                        end
                    end
                end
                StRdAck: begin
                    if (w_scl_rise) begin
                        w_mack_d = w_sda;
                    end else if (w_scl_fall) begin
                        if (r_mack == ACK) begin
                            w_state_d = StRdByte;
                            if (r_byte_idx == LAST_BYTE) begin
                                w_byte_idx_d = '0;
                                w_ptr_d      = w_ptr_inc;
                                w_mem_re     = 1'b1;
                                w_mem_raddr  = w_ptr_inc;
                                w_load_d     = 1'b1;
                            end else begin
                                w_byte_idx_d = r_byte_idx + 1'b1;
                                w_prime_d    = 1'b1;
                            end
                        end else begin
                            w_state_d = StWaitStop;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, synchroniser and datapath registers; reset also frees sda at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_scl_sync  <= 2'b11;
            r_sda_sync  <= 2'b11;
            r_scl_prev  <= 1'b1;
            r_sda_prev  <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_idx  <= '0;
            r_ptr       <= '0;
            r_wr_buf    <= '0;
            r_rd_word   <= '0;
            r_curr_data <= '0;
            r_load      <= 1'b0;
            r_prime     <= 1'b0;
            r_mack      <= ACK;
            r_sda_oe    <= 1'b0;
            r_rcvd_addr <= '0;
            r_rcvd_mode <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_scl_sync  <= {r_scl_sync[0], scl};
            r_sda_sync  <= {r_sda_sync[0], sda};
            r_scl_prev  <= w_scl;
            r_sda_prev  <= w_sda;
            r_shift     <= w_shift_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_byte_idx  <= w_byte_idx_d;
            r_ptr       <= w_ptr_d;
            r_wr_buf    <= w_wr_buf_d;
            r_rd_word   <= w_rd_word_d;
            r_curr_data <= w_curr_data_d;
            r_load      <= w_load_d;
            r_prime     <= w_prime_d;
            r_mack      <= w_mack_d;
            r_sda_oe    <= w_sda_oe_d;
            r_rcvd_addr <= w_rcvd_addr_d;
            r_rcvd_mode <= w_rcvd_mode_d;
        end
    end

    assign sda                 = r_sda_oe ? 1'b0 : 1'bz;
    assign curr_data           = r_curr_data;
    assign rcvd_device_address = r_rcvd_addr;
    assign rcvd_mode           = r_rcvd_mode;
    assign state               = r_state;
    assign busy                = (r_state != StIdle);

endmodule

// File: doc/i2c_sram_burst.md
# i2c_sram_burst

Parametrised I2C-slave SRAM, the successor to the fixed 16-bit embedded I2C SRAM. It adds configurable word width, depth and address width, multi-word burst read/write with address auto-increment and wrap, current-address reads, and repeated-start handling. The slave is oversampled on a system clock and sits on the shared `sda`/`scl` bus beside the existing embedded part. It drives `sda` open-drain only.

## Interface
Parameters:
- `ADDR_W`, default 8: memory address width. Legal range 1..8; sent as one address byte, upper bits ignored.
- `DATA_BYTES`, default 2: bytes per memory word. Legal range 1..4; MSB byte first on the bus.
- `DEPTH`, default 2**ADDR_W: number of words. Must be ≤ 2**ADDR_W.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `reset`  in  1  asynchronous, active-low reset.
- `scl`  in  1  I2C clock from the master.
- `sda`  inout  1  I2C data. Driven 0 or released to Z, never driven 1; bus is pulled up (`tri1`).
- `my_addr`  in  7  device address; must be static while `busy`.
- `curr_data`  out  8*DATA_BYTES  last word written to or read from memory.
- `rcvd_device_address`  out  7  last device address received.
- `rcvd_mode`  out  1  last R/W bit received (1 = read).
- `state`  out  4  current FSM state encoding.
- `busy`  out  1  high from START to STOP.

## Operation
- `scl`/`sda` pass through 2-flop synchronisers. Rise/fall edges are detected on the synchronised copies.
- START (sda falls while scl high) moves to DEV_ADDR from any state; this is the repeated-start path.
- STOP (sda rises while scl high) moves to IDLE from any state.
- Bits are sampled on scl rise and driven after scl fall, MSB first.
- FSM states and codes: IDLE=0, DEV_ADDR=1, DEV_ACK=2, MEM_ADDR=3, MEM_ACK=4, WR_BYTE=5, WR_ACK=6, RD_BYTE=7, RD_ACK=8, WAIT_STOP=9.
- DEV_ADDR: shift 7 address bits plus the R/W bit; latch `rcvd_device_address` and `rcvd_mode`.
  - Match with W: ACK, then MEM_ADDR.
  - Match with R: ACK, then RD_BYTE.
  - Mismatch: no ACK, go to WAIT_STOP.
- MEM_ADDR: load pointer = byte[ADDR_W-1:0], ACK, then WR_BYTE.
- WR_BYTE/WR_ACK: bytes accumulate into a word buffer; every byte is ACKed.
  - After the DATA_BYTES-th byte, write the word to pointer, update `curr_data`, and advance pointer = (pointer+1) mod DEPTH.
  - A STOP or START arriving mid-word discards the partial word; memory is unchanged.
- Read: RD_BYTE starts from a word fetched at pointer on entry. With no MEM_ADDR phase this is a current-address read.
  - Shift the bytes out MSB first; RD_ACK samples the master's response after each byte.
  - Master ACK: continue. After the last byte of a word, advance pointer and fetch the next word (burst).
  - Master NACK: release `sda`, go to WAIT_STOP.
- The pointer persists across transactions and clears only on reset. Memory contents are not cleared by reset.
- Out-of-range pointer (DEPTH < 2**ADDR_W): wrap to 0 on load.

## Timing
- Reset values: `sda` released, `state`=IDLE, `busy`=0, `rcvd_device_address`=0, `rcvd_mode`=0, `curr_data`=0, pointer=0, word buffer=0.
- Reset asserted mid-transfer releases `sda` asynchronously; the bus is free within 0 cycles.
- Edge detection latency is 3 clk from a pin change.
- The master must hold scl high and scl low each ≥ 8 clk. Setup/hold of sda around scl edges must be ≥ 4 clk.
- ACK drive: `sda` goes low 1 clk after the detected 8th-bit scl fall. It is released 1 clk after the detected 9th scl fall.
- Memory read is synchronous with 1 clk latency. The fetch is issued on the detected scl fall that ends the ACK, so data is valid before the first data bit is driven.
- The memory write strobe lasts 1 clk, on the detected scl rise of the last data bit. The ACK follows.
- START and STOP take priority over a same-cycle scl edge.

## Structure
- Shared package `i2c_sram_pkg`: state encoding constants, `ACK`=0/`NACK`=1, and the default parameter values.
- One sub-module, `sram_sp`: a parametrised single-port synchronous RAM (DEPTH × 8*DATA_BYTES) with write enable and registered read. The existing `sram` is generalised into it.
- Synchroniser and edge detect stay inline.

## Test plan
- Write 2203 to addr 50 (my_addr=0x3C), then a random read of addr 50 (repeated start) → 2203 received, master NACK, `state` returns to IDLE after STOP.
- Burst write 5724, 1234, 1067 starting at addr 254 → mem[254]=5724, mem[255]=1234, mem[0]=1067, pointer=1.
- Device address 0x3D → `sda` stays high in the 9th clock, block sits in WAIT_STOP, memory unchanged, `rcvd_device_address`=0x3D.
- Write addr 102 plus one data byte, then STOP → mem[102] unchanged. A following current-address read returns mem[102].
- Burst read from addr 50 with master ACK after word 1 and NACK after word 2 → mem[50] then mem[51] delivered, `sda` released after the NACK.
- Assert `reset` mid-read while the slave drives 0 → `sda` is Z at once, `state`=IDLE, and a subsequent write/read to addr 186 works.
